// File: rtl/beep_sequencer_pkg.sv
// Shared types and default timing for the buzzer sequencer.
// Defaults give a ~625 Hz tone with 0.25 s beeps and gaps at 50 MHz.
package beep_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    localparam int unsigned DEF_MAX_CODE  = 9;
    localparam int unsigned DEF_TONE_HALF = 40001;
    localparam int unsigned DEF_ON_CYC    = 12500000;
    localparam int unsigned DEF_OFF_CYC   = 12500000;

    localparam int unsigned CODE_W  = 8;
    localparam int unsigned CUR_W   = 4;
    localparam int unsigned TIMER_W = 24;
    localparam int unsigned TONE_W  = 16;

    // True for codes that produce at least one beep.
    function automatic logic code_playable(input logic [CODE_W-1:0] code,
                                           input int unsigned       max_code);
        return (code != '0) && (32'(code) <= max_code);
    endfunction

endpackage

// File: rtl/beep_tone.sv
// Square-wave tone generator; silent and re-phased whenever en is low.
module beep_tone
    import beep_sequencer_pkg::*;
#(
    parameter int unsigned TONE_HALF = DEF_TONE_HALF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic beep_pin
);

    localparam logic [TONE_W-1:0] HALF_LAST = TONE_W'(TONE_HALF - 1);

    logic [TONE_W-1:0] half_cnt;
    logic              tone_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_cnt <= '0;
            tone_q   <= 1'b0;
        end else if (!en) begin
            half_cnt <= '0;
            tone_q   <= 1'b0;
        end else if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
            tone_q   <= ~tone_q;
        end else begin
            half_cnt <= half_cnt + TONE_W'(1);
        end
    end

    // Gate with en so the pin is low on the very first silent cycle,
    // even if the last tone cycle landed on a toggle.
    assign beep_pin = tone_q & en;

endmodule

// File: rtl/beep_sequencer.sv
// Plays result code N as N short beeps; one code may wait behind the one playing.
module beep_sequencer
    import beep_sequencer_pkg::*;
#(
    parameter int unsigned TONE_HALF = DEF_TONE_HALF,
    parameter int unsigned ON_CYC    = DEF_ON_CYC,
    parameter int unsigned OFF_CYC   = DEF_OFF_CYC,
    parameter int unsigned MAX_CODE  = DEF_MAX_CODE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [CODE_W-1:0] req_code,
    output logic              req_ready,
    output logic              beep_pin,
    output logic              busy,
    output logic [CUR_W-1:0]  cur_code,
    output logic              drop_pulse
);

    localparam logic [TIMER_W-1:0] ON_LAST  = TIMER_W'(ON_CYC - 1);
    localparam logic [TIMER_W-1:0] OFF_LAST = TIMER_W'(OFF_CYC - 1);

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic [CUR_W-1:0]   remaining;
    logic               pend_valid;
    logic [CUR_W-1:0]   pend_code;

    logic             code_ok;
    logic             take;
    logic             bypass;
    logic             store_pend;
    logic [CUR_W-1:0] code4;

    assign req_ready  = !pend_valid;
    assign code_ok    = code_playable(req_code, MAX_CODE);
    assign take       = req_valid && req_ready && code_ok;
    assign code4      = CUR_W'(req_code);
    // A code arriving on the final silent cycle of an exhausted pattern starts directly.
    assign bypass     = (state == ST_OFF) && (timer == OFF_LAST) && (remaining == '0);
    assign store_pend = (state != ST_IDLE) && !bypass;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            timer      <= '0;
            remaining  <= '0;
            pend_valid <= 1'b0;
            pend_code  <= '0;
            busy       <= 1'b0;
            cur_code   <= '0;
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= req_valid && !req_ready && code_ok;

            if (take && store_pend) begin
                pend_valid <= 1'b1;
                pend_code  <= code4;
            end

            case (state)
                ST_IDLE: begin
                    if (take) begin
                        state     <= ST_ON;
                        timer     <= '0;
                        remaining <= code4;
                        cur_code  <= code4;
                        busy      <= 1'b1;
                    end
                end
                ST_ON: begin
                    if (timer == ON_LAST) begin
                        state     <= ST_OFF;
                        timer     <= '0;
                        remaining <= remaining - CUR_W'(1);
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                ST_OFF: begin
                    if (timer != OFF_LAST) begin
                        timer <= timer + TIMER_W'(1);
                    end else begin
                        timer <= '0;
                        if (remaining != '0) begin
                            state <= ST_ON;
                        end else if (pend_valid) begin
                            state      <= ST_ON;
                            remaining  <= pend_code;
                            cur_code   <= pend_code;
                            pend_valid <= 1'b0;
                        end else if (take) begin
                            state     <= ST_ON;
                            remaining <= code4;
                            cur_code  <= code4;
                        end else begin
                            state    <= ST_IDLE;
                            cur_code <= '0;
                            busy     <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    timer    <= '0;
                    cur_code <= '0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    beep_tone #(
        .TONE_HALF(TONE_HALF)
    ) u_tone (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (state == ST_ON),
        .beep_pin(beep_pin)
    );

endmodule
